// File: rtl/fib_loop_monitor.sv
// In-design checker for the bounded increment loop stage: watches i/n/k every clock,
// enforces the loop invariants and reports termination or a sticky failure cause.
module fib_loop_monitor #(
   parameter int WIDTH   = 11,
   parameter int STEP    = 50,
   parameter int TIMEOUT = 2047
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] i_in,
   input  logic [WIDTH-1:0] n_in,
   input  logic [WIDTH-1:0] k_in,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [2:0]       fail_code,
   output logic [WIDTH-1:0] steps,
   output logic [WIDTH-1:0] k_final,
   output logic             prop_ok
);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_DONE, S_FAIL} state_t;

   localparam logic [WIDTH-1:0] L_STEP    = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] L_TIMEOUT = WIDTH'(TIMEOUT);

   state_t           r_state;
   logic             r_busy, r_done, r_fail, r_prop_ok;
   logic [2:0]       r_fail_code;
   logic [WIDTH-1:0] r_steps, r_k_final, r_n_ref, r_i_prev, r_k_exp, r_timer;

   logic [WIDTH-1:0] w_i_inc, w_k_step, w_timer_inc;
   logic             w_is_inc, w_is_hold, w_k_ok, w_term;
   logic [2:0]       w_check_code, w_code;

   assign w_i_inc     = r_i_prev + WIDTH'(1);
   assign w_k_step    = r_k_exp + L_STEP;
   assign w_timer_inc = r_timer + WIDTH'(1);
   assign w_is_inc    = (i_in == w_i_inc);
   assign w_is_hold   = (i_in == r_i_prev);
   assign w_k_ok      = w_is_inc ? (k_in == w_k_step) : (k_in == r_k_exp);
   assign w_term      = (w_check_code == 3'd0) && (i_in == r_n_ref);

   // Sample checks in priority order; a terminating sample masks the timeout.
   always_comb begin
      w_check_code = 3'd0;
      if (!w_is_inc && !w_is_hold)
         w_check_code = 3'd1;
      else if (n_in != r_n_ref)
         w_check_code = 3'd2;
      else if (!w_k_ok)
         w_check_code = 3'd3;
      else if (i_in > r_n_ref)
         w_check_code = 3'd4;

      w_code = w_check_code;
      if (w_check_code == 3'd0 && !w_term && w_timer_inc == L_TIMEOUT)
         w_code = 3'd5;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_prop_ok   <= 1'b0;
         r_fail_code <= 3'd0;
         r_steps     <= '0;
         r_k_final   <= '0;
         r_n_ref     <= '0;
         r_i_prev    <= '0;
         r_k_exp     <= '0;
         r_timer     <= '0;
      end else if (!enable) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_prop_ok   <= 1'b0;
         r_fail_code <= 3'd0;
         r_steps     <= '0;
         r_k_final   <= '0;
         r_n_ref     <= '0;
         r_i_prev    <= '0;
         r_k_exp     <= '0;
         r_timer     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_ARMED;
               r_busy  <= 1'b1;
            end
            S_ARMED: begin
               r_n_ref  <= n_in;
               r_i_prev <= i_in;
               r_k_exp  <= k_in;
               r_steps  <= '0;
               r_timer  <= '0;
               if (i_in != '0 || k_in != '0) begin
                  r_state     <= S_FAIL;
                  r_busy      <= 1'b0;
                  r_fail      <= 1'b1;
                  r_fail_code <= 3'd6;
               end else if (n_in == '0) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_k_final <= '0;
                  r_prop_ok <= 1'b0;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_timer <= w_timer_inc;
               if (w_code != 3'd0) begin
                  r_state     <= S_FAIL;
                  r_busy      <= 1'b0;
                  r_fail      <= 1'b1;
                  r_fail_code <= w_code;
               end else begin
                  if (w_is_inc) begin
                     r_i_prev <= i_in;
                     r_k_exp  <= w_k_step;
                     r_steps  <= r_steps + WIDTH'(1);
                  end
                  if (w_term) begin
                     r_state   <= S_DONE;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_k_final <= k_in;
                     r_prop_ok <= (k_in > r_n_ref);
                  end
               end
            end
            S_DONE, S_FAIL: begin
               r_state <= r_state;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign fail      = r_fail;
   assign fail_code = r_fail_code;
   assign steps     = r_steps;
   assign k_final   = r_k_final;
   assign prop_ok   = r_prop_ok;

endmodule

// File: tb/tb_fib_loop_monitor.sv
// Scenario bench for fib_loop_monitor: expected outcomes are queued when a scenario
// starts and popped once the monitor decides (done or fail).
module tb_fib_loop_monitor;
   localparam int W = 11;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] i_in = '0, n_in = '0, k_in = '0;

   logic         busy, done, fail, prop_ok;
   logic [2:0]   fail_code;
   logic [W-1:0] steps, k_final;
   logic         t_busy, t_done, t_fail, t_prop_ok;
   logic [2:0]   t_fail_code;
   logic [W-1:0] t_steps, t_k_final;

   fib_loop_monitor #(.WIDTH(W), .STEP(50), .TIMEOUT(2047)) dut (
      .clk(clk), .rst(rst), .enable(enable), .i_in(i_in), .n_in(n_in), .k_in(k_in),
      .busy(busy), .done(done), .fail(fail), .fail_code(fail_code),
      .steps(steps), .k_final(k_final), .prop_ok(prop_ok));

   // Short-timeout copy fed with the same stimulus
   fib_loop_monitor #(.WIDTH(W), .STEP(50), .TIMEOUT(20)) dut_to (
      .clk(clk), .rst(rst), .enable(enable), .i_in(i_in), .n_in(n_in), .k_in(k_in),
      .busy(t_busy), .done(t_done), .fail(t_fail), .fail_code(t_fail_code),
      .steps(t_steps), .k_final(t_k_final), .prop_ok(t_prop_ok));

   always #5 clk = ~clk;

   typedef struct packed {
      logic         busy;
      logic         done;
      logic         fail;
      logic [2:0]   code;
      logic [W-1:0] steps;
      logic [W-1:0] k_final;
      logic         prop_ok;
   } obs_t;

   obs_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic obs_t sample_obs(input bit use_to);
      obs_t o;
      if (use_to) o = '{t_busy, t_done, t_fail, t_fail_code, t_steps, t_k_final, t_prop_ok};
      else        o = '{busy, done, fail, fail_code, steps, k_final, prop_ok};
      return o;
   endfunction

   function automatic obs_t mk(input logic d, input logic f, input logic [2:0] c,
                               input int s, input int kf, input logic p);
      obs_t o;
      o = '{1'b0, d, f, c, W'(s), W'(kf), p};
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("busy=%0d done=%0d fail=%0d code=%0d steps=%0d k_final=%0d prop_ok=%0d",
                       o.busy, o.done, o.fail, o.code, o.steps, o.k_final, o.prop_ok);
   endfunction

   task automatic drive(input int i, input int n, input int k);
      @(negedge clk);
      i_in = W'(i);
      n_in = W'(n);
      k_in = W'(k);
   endtask

   // Returns at the negedge just before the ARMED start sample.
   task automatic arm(input int n, input int i0);
      @(negedge clk);
      enable = 1'b0;
      i_in = W'(i0);
      n_in = W'(n);
      k_in = '0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_decide(input bit use_to, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (use_to ? (t_done | t_fail) : (done | fail)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      obs_t o, e;
      sb.push_back(mk(0, 0, 3'd0, 0, 0, 0));
      repeat (2) @(negedge clk);
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset: got %s want %s", fmt(o), fmt(e));
      end
      rst = 1'b1;
   endtask

   task automatic test_nominal;
      obs_t o, e;
      bit ok;
      sb.push_back(mk(1, 0, 3'd0, 40, 2000, 1));
      arm(40, 0);
      for (int i = 1; i <= 40; i++) begin
         drive(i, 40, 50 * i);
         if (i == 5) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL nominal_busy: got %0d want 1", busy);
            end
         end
      end
      wait_decide(0, 5, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL nominal_timeout: got no decision want done");
      end
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL nominal: got %s want %s", fmt(o), fmt(e));
      end
      $display("nominal run: %s", fmt(o));
   endtask

   task automatic test_enable_clear;
      obs_t o, e;
      sb.push_back(mk(0, 0, 3'd0, 0, 0, 0));
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL enable_clear: got %s want %s", fmt(o), fmt(e));
      end
   endtask

   task automatic test_k_error;
      obs_t o, e;
      bit seen_done = 1'b0;
      sb.push_back(mk(0, 1, 3'd3, 2, 0, 0));
      arm(40, 0);
      for (int i = 1; i <= 40; i++) begin
         drive(i, 40, (i == 3) ? 151 : 50 * i);
         if (done) seen_done = 1'b1;
      end
      repeat (2) @(negedge clk);
      if (done) seen_done = 1'b1;
      checks++;
      if (seen_done) begin
         errors++;
         $display("FAIL k_error_done: got done=1 want done never");
      end
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL k_error: got %s want %s", fmt(o), fmt(e));
      end
      $display("k error run: %s", fmt(o));
   endtask

   task automatic test_n_change;
      obs_t o, e;
      bit ok;
      sb.push_back(mk(0, 1, 3'd2, 9, 0, 0));
      arm(40, 0);
      for (int i = 1; i <= 12; i++) drive(i, (i >= 10) ? 41 : 40, 50 * i);
      wait_decide(0, 5, ok);
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) begin
         errors++;
         $display("FAIL n_change: got %s want %s", fmt(o), fmt(e));
      end
      $display("n change run: %s", fmt(o));
   endtask

   task automatic test_i_jump;
      obs_t o, e;
      bit ok;
      sb.push_back(mk(0, 1, 3'd1, 5, 0, 0));
      arm(40, 0);
      for (int i = 1; i <= 5; i++) drive(i, 40, 50 * i);
      drive(7, 40, 350);
      drive(8, 40, 400);
      wait_decide(0, 5, ok);
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) begin
         errors++;
         $display("FAIL i_jump: got %s want %s", fmt(o), fmt(e));
      end
      $display("i jump run: %s", fmt(o));
   endtask

   task automatic test_bad_start;
      obs_t o, e;
      bit ok;
      sb.push_back(mk(0, 1, 3'd6, 0, 0, 0));
      arm(40, 3);
      wait_decide(0, 5, ok);
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) begin
         errors++;
         $display("FAIL bad_start: got %s want %s", fmt(o), fmt(e));
      end
      $display("bad start run: %s", fmt(o));
   endtask

   task automatic test_n_zero;
      obs_t o, e;
      sb.push_back(mk(1, 0, 3'd0, 0, 0, 0));
      arm(0, 0);
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL n_zero_latency: got done=%0d want 1", done);
      end
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL n_zero: got %s want %s", fmt(o), fmt(e));
      end
      $display("n zero run: %s", fmt(o));
   endtask

   task automatic test_timeout;
      obs_t o, e;
      bit ok;
      sb.push_back(mk(0, 1, 3'd5, 4, 0, 0));
      arm(40, 0);
      for (int i = 1; i <= 4; i++) drive(i, 40, 50 * i);
      wait_decide(1, 30, ok);
      o = sample_obs(1);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) begin
         errors++;
         $display("FAIL timeout: got %s want %s", fmt(o), fmt(e));
      end
      checks++;
      if (busy !== 1'b1 || fail !== 1'b0) begin
         errors++;
         $display("FAIL timeout_long: got busy=%0d fail=%0d want busy=1 fail=0", busy, fail);
      end
      $display("timeout run: %s", fmt(o));
   endtask

   task automatic test_mid_reset;
      obs_t o, e;
      bit ok;
      sb.push_back(mk(0, 0, 3'd0, 0, 0, 0));
      sb.push_back(mk(0, 1, 3'd6, 0, 0, 0));
      arm(40, 0);
      for (int i = 1; i <= 5; i++) drive(i, 40, 50 * i);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL mid_reset: got %s want %s", fmt(o), fmt(e));
      end
      #1 rst = 1'b1;
      // With i_in left at 5, a fresh ARMED start sample must flag a bad start
      wait_decide(0, 6, ok);
      o = sample_obs(0);
      e = sb.pop_front();
      checks++;
      if (!ok || o !== e) begin
         errors++;
         $display("FAIL mid_reset_restart: got %s want %s", fmt(o), fmt(e));
      end
      $display("mid reset restart: %s", fmt(o));
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_enable_clear();
      test_k_error();
      test_n_change();
      test_i_jump();
      test_bad_start();
      test_n_zero();
      test_timeout();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fib_loop_monitor.md
Name: fib_loop_monitor

Overview:
- Downstream consumer of the bounded increment loop stage, which produces the i/n/k registers: i counts up to bound n, and k advances by a fixed step per i increment.
- Samples the loop's outputs every clock and checks the loop invariants.
- Detects termination, reports the step count and final k, and raises a sticky fail flag with a cause code.
- Sits between the loop stage and the testbench/scoreboard as an in-design checker.

Parameters:
WIDTH, 11, bit width of i, n, k and internal counters
STEP, 50, expected k increment per i increment
TIMEOUT, 2047, max cycles in RUN before a timeout fail (must fit WIDTH bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
enable  input  1  arm the monitor; low returns it to IDLE synchronously
i_in  input  WIDTH  loop index from the loop stage
n_in  input  WIDTH  loop bound from the loop stage
k_in  input  WIDTH  accumulator from the loop stage
busy  output  1  high in ARMED or RUN
done  output  1  sticky, high in DONE
fail  output  1  sticky, high in FAIL
fail_code  output  3  cause of failure, 0 when not failed
steps  output  WIDTH  number of observed i increments
k_final  output  WIDTH  k_in captured at termination
prop_ok  output  1  in DONE: 1 if k_final > n_ref; 0 otherwise

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, fail, prop_ok = 0; fail_code, steps, k_final = 0; all internal registers = 0.
- States: IDLE, ARMED, RUN, DONE, FAIL. Encoding is free.
- enable=0 in any state: next state IDLE; all outputs are cleared as at reset, synchronously.
- IDLE -> ARMED when enable=1.
- ARMED, one cycle, start sample:
  - Capture n_ref=n_in, i_prev=i_in, k_exp=k_in, steps=0, timer=0.
  - Require i_in=0 and k_in=0; otherwise -> FAIL, code 6 (bad start).
  - If n_in=0 -> DONE directly, k_final=0.
  - Else -> RUN.
- RUN: one check per cycle, all on the same sample. Fail codes in priority order (lowest code wins):
  - 1: i_in not equal to i_prev and not equal to i_prev+1 (i jump).
  - 2: n_in != n_ref (bound changed).
  - 3: k_in mismatch. If i_in = i_prev+1, expected k_in = (k_exp+STEP) mod 2^WIDTH. If i_in = i_prev, expected k_in = k_exp.
  - 4: i_in > n_ref (overrun).
  - 5: timer reaches TIMEOUT while still in RUN.
- RUN update when no fail:
  - On an increment: i_prev <= i_in, k_exp <= k_exp+STEP (truncated), steps <= steps+1.
  - timer increments every RUN cycle.
- Termination: in RUN, a sample with i_in = n_ref that passes all checks -> DONE next cycle, with k_final=k_in.
  - The terminating sample may itself be the final increment.
  - The loop stage holds afterwards; DONE ignores further samples.
- FAIL: fail=1, fail_code is held; steps holds its value from the failing cycle. Exit only via enable=0 or reset.
- DONE: done=1; prop_ok = (k_final > n_ref), unsigned compare. Exit only via enable=0 or reset.
- Simultaneous events: a sample that both fails a check and would terminate goes to FAIL. Timeout and termination on the same sample -> DONE.
- Arithmetic: all additions wrap modulo 2^WIDTH, no saturation. Compares are unsigned.
- Latency: done/fail assert one clock after the deciding sample.
- Reset mid-operation: immediate return to reset values; no state is retained.

Test Plan:
- Loop stage reset to i=0, n=40, k=0, then free-running, enable=1 -> done=1 after 40 increments; steps=40, k_final=2000, prop_ok=1, fail=0.
- Same run, but force k_in to 151 at i=3 -> fail=1, fail_code=3, steps=2, done never asserts.
- n_in changed from 40 to 41 at i=10 -> fail_code=2.
- i_in jumps 5 -> 7 -> fail_code=1. Separately, start with i_in=3 at ARMED -> fail_code=6.
- n=0 at start -> DONE the cycle after ARMED; steps=0, k_final=0, prop_ok=0.
- Index stuck at 4 with TIMEOUT=20 -> fail_code=5. Separately, pull rst low mid-RUN -> all outputs 0 immediately, state IDLE.
